subkey_store: RTL

//  Consumer end of the Serpent key-schedule output. Captures the 33 128-bit round subkeys
//  (K0..K32) delivered as address/data writes, and tracks which entries are loaded.
//  On request it streams them to the bitslice cipher datapath over a valid/ready handshake:

---
 rtl/subkey_store.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/subkey_store.sv
// subkey_store: holds the 33 Serpent round subkeys written by the key schedule
// and streams them to the round engine over a valid/ready handshake. Keys go out
// in ascending order for encryption and in descending order for decryption.
module subkey_store #(
    parameter int NKEYS = 33,
    parameter int KW    = 128
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_clear,
    input  logic          i_wr_en,
    input  logic [5:0]    i_wr_addr,
    input  logic [KW-1:0] i_wr_data,
    output logic          o_loaded,
    input  logic          i_start,
    input  logic          i_dir,
    output logic          o_busy,
    output logic [KW-1:0] o_key,
    output logic [5:0]    o_key_round,
    output logic          o_key_valid,
    input  logic          i_key_ready,
    output logic          o_done,
    output logic          o_err
);

    localparam logic [5:0] LAST = 6'(NKEYS - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NKEYS-1:0]  mask_q, mask_d;
    logic              loaded_q, loaded_d;
    logic              dir_q, dir_d;
    logic [KW-1:0]     key_q, key_d;
    logic [5:0]        round_q, round_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [KW-1:0]     mem_q [NKEYS];

    logic              wr_addr_ok;
    logic              wr_ok;
    logic              last_key;
    logic [5:0]        start_idx;
    logic [5:0]        step_idx;

    // Write qualification and stream index arithmetic
    always_comb begin
        wr_addr_ok = (i_wr_addr < 6'(NKEYS));
        wr_ok      = i_wr_en && wr_addr_ok && (state_q != STREAM) && !i_clear;
        start_idx  = i_dir ? LAST : 6'd0;
        step_idx   = dir_q ? (round_q - 6'd1) : (round_q + 6'd1);
        last_key   = dir_q ? (round_q == 6'd0) : (round_q == LAST);
    end

    // Key storage: no reset, writes are locked out while streaming
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    // Next-state and output logic; clear overrides any write or start
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dir_d   = dir_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (i_clear) begin
            state_d = IDLE;
            mask_d  = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (i_wr_en) begin
                        if (wr_addr_ok) begin
                            mask_d[i_wr_addr] = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (state_q == DONE) begin
                        state_d = IDLE;
                    end else if (i_start) begin
                        if (loaded_q) begin
                            state_d = STREAM;
                            dir_d   = i_dir;
                            round_d = start_idx;
                            key_d   = mem_q[start_idx];
                            valid_d = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (i_wr_en) begin
                        err_d = 1'b1;
                    end
                    if (valid_q && i_key_ready) begin
                        if (last_key) begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            round_d = step_idx;
                            key_d   = mem_q[step_idx];
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        loaded_d = &mask_d;
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            loaded_q <= 1'b0;
            dir_q    <= 1'b0;
            key_q    <= '0;
            round_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            loaded_q <= loaded_d;
            dir_q    <= dir_d;
            key_q    <= key_d;
            round_q  <= round_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_loaded    = loaded_q;
    assign o_busy      = busy_q;
    assign o_key       = key_q;
    assign o_key_round = round_q;
    assign o_key_valid = valid_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule
